seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_step.sv | 25 ++
 rtl/seq_divider.sv | 111 +++++++++++
 tb/tb_seq_divider.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants, state encoding and helpers for seq_divider
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

  // Two's-complement negate when neg is set, pass through otherwise.
  function automatic logic [DIV_WIDTH-1:0] neg_if(input logic neg,
                                                  input logic [DIV_WIDTH-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one radix-2 restoring division iteration (combinational)
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  // partial is the 33-bit shifted remainder; the kept remainder is always
  // below the divisor, so the difference fits back into WIDTH bits.
  logic [WIDTH:0] partial;
  logic           fits;

  // Shift in the next dividend bit, trial-subtract, keep or restore.
  always_comb begin
    partial = {rem_in, quo_in[WIDTH-1]};
    fits    = (partial >= {1'b0, divisor});
    rem_out = fits ? (partial[WIDTH-1:0] - divisor) : partial[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - fixed-latency sequential signed/unsigned divider
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             sign,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  div_state_t       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo_w, rem_w, dvs_r;
  logic [WIDTH-1:0] quo_step, rem_step;
  logic             neg_q, neg_r, dvs_zero;
  logic             dvd_neg, dvs_neg;

  assign dvd_neg = sign & dividend[WIDTH-1];
  assign dvs_neg = sign & divisor[WIDTH-1];

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_w),
    .quo_in  (quo_w),
    .divisor (dvs_r),
    .rem_out (rem_step),
    .quo_out (quo_step)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and status decode; start is only looked at in IDLE.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) state_next = CALC;
      CALC: begin
        busy = 1'b1;
        if (cnt == CNT_W'(DIV_ITERS - 1)) state_next = FIXUP;
      end
      FIXUP: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration and sign fix-up; results only change in FIXUP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      quo_w       <= '0;
      rem_w       <= '0;
      dvs_r       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dvs_zero    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          quo_w       <= neg_if(dvd_neg, dividend);
          rem_w       <= '0;
          dvs_r       <= neg_if(dvs_neg, divisor);
          neg_q       <= dvd_neg ^ dvs_neg;
          neg_r       <= dvd_neg;
          dvs_zero    <= (divisor == '0);
          cnt         <= '0;
          div_by_zero <= 1'b0;
        end
        CALC: begin
          quo_w <= quo_step;
          rem_w <= rem_step;
          cnt   <= cnt + 1'b1;
        end
        FIXUP: begin
          // A zero divisor leaves the dividend magnitude in rem_w, so the
          // remainder sign rule restores the original dividend; only the
          // quotient needs forcing to all ones.
          quotient    <= dvs_zero ? '1 : neg_if(neg_q, quo_w);
          remainder   <= neg_if(neg_r, rem_w);
          div_by_zero <= dvs_zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        sign;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int total_cnt;
  int pass_cnt;

  seq_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .sign        (sign),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Cycle 0: drive start with operands; after the accepting edge scramble inputs.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(posedge clk); #1;
    dividend = a; divisor = b; sign = s; start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    sign     = ~s;
  endtask

  // Counts negedges from the next one (c=1) until done; optional start pulse at pulse_c.
  task automatic expect_result(input string tag, input int lat_exp, input logic busy1,
                               input int pulse_c, input logic [31:0] eq,
                               input logic [31:0] er, input logic ez);
    int lat;
    lat = 0;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) check({tag, " busy_c1"}, 32'(busy), 32'(busy1));
      if (c == pulse_c) begin
        start = 1'b1; dividend = 32'd9; divisor = 32'd3; sign = 1'b0;
      end else if (c >= 2) begin
        start = 1'b0;
      end
      if (done) lat = c;
    end
    check({tag, " latency"}, 32'(lat), 32'(lat_exp));
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " dbz"}, 32'(div_by_zero), 32'(ez));
  endtask

  task automatic watch_no_done(input string tag, input int n);
    int pulses;
    pulses = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check({tag, " extra_done"}, 32'(pulses), 32'd0);
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    rst_n     = 1'b0;
    start     = 1'b1;
    dividend  = 32'd55;
    divisor   = 32'd5;
    sign      = 1'b0;

    // Reset held with start asserted: reset wins, everything stays cleared.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst quotient", quotient, 32'd0);
    check("rst remainder", remainder, 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;

    launch(32'd100, 32'd7, 1'b0);
    expect_result("u100_7", 34, 1'b1, 0, 32'd14, 32'd2, 1'b0);
    @(negedge clk);
    check("u100_7 pulse_width", 32'(done), 32'd0);
    check("u100_7 busy_after", 32'(busy), 32'd0);

    launch(32'hFFFF_FFF9, 32'd2, 1'b1);
    expect_result("s-7_2", 34, 1'b1, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);

    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    expect_result("uff_ff", 34, 1'b1, 0, 32'd1, 32'd0, 1'b0);

    launch(32'hFFFF_FFF9, 32'd2, 1'b0);
    expect_result("ufff9_2", 34, 1'b1, 0, 32'h7FFF_FFFC, 32'd1, 1'b0);

    launch(32'hFFFF_FF9C, 32'd7, 1'b1);
    expect_result("s-100_7", 34, 1'b1, 0, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);

    launch(32'd100, 32'hFFFF_FFF9, 1'b1);
    expect_result("s100_-7", 34, 1'b1, 0, 32'hFFFF_FFF2, 32'd2, 1'b0);

    launch(32'hFFFF_FFFB, 32'd0, 1'b1);
    expect_result("s-5_0", 34, 1'b1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
    repeat (3) @(negedge clk);
    check("dbz held", 32'(div_by_zero), 32'd1);

    launch(32'd12345, 32'd0, 1'b0);
    expect_result("u12345_0", 34, 1'b1, 0, 32'hFFFF_FFFF, 32'd12345, 1'b1);

    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    expect_result("ovf", 34, 1'b1, 0, 32'h8000_0000, 32'd0, 1'b0);

    // Start pulse with 9/3 in cycle 10 must be ignored entirely.
    launch(32'd100, 32'd7, 1'b0);
    expect_result("busy_start", 34, 1'b1, 10, 32'd14, 32'd2, 1'b0);
    watch_no_done("busy_start", 40);

    // Start raised in the DONE cycle is ignored, accepted in the next IDLE.
    launch(32'd1000, 32'd10, 1'b0);
    expect_result("chain_a", 34, 1'b1, 0, 32'd100, 32'd0, 1'b0);
    start = 1'b1; dividend = 32'd50; divisor = 32'd5; sign = 1'b0;
    expect_result("chain_b", 35, 1'b0, 0, 32'd10, 32'd0, 1'b0);

    // Reset in cycle 15 of an operation aborts it.
    launch(32'd1000, 32'd3, 1'b0);
    for (int c = 1; c <= 15; c++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort quotient", quotient, 32'd0);
    check("abort remainder", remainder, 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    watch_no_done("abort", 40);

    launch(32'd77, 32'd5, 1'b0);
    expect_result("post_rst", 34, 1'b1, 0, 32'd15, 32'd2, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
